// File: rtl/l2_bank_arbiter.sv
// l2_bank_arbiter: round-robin arbiter sharing one fixed-latency single-ported SRAM cut among N_REQ requesters.
// Build macro L2_ARB_INIT_EN adds a post-reset zero-fill sweep of the cut before any requester is served.
module l2_bank_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int DATA_WIDTH  = 64,
    parameter  int N_WORDS     = 16384,
    parameter  int MEM_LATENCY = 1,
    localparam int ADDR_WIDTH  = $clog2(N_WORDS),
    localparam int BE_WIDTH    = DATA_WIDTH / 8,
    localparam int IDX_WIDTH   = $clog2(N_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ-1:0]                     we_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [N_REQ-1:0][BE_WIDTH-1:0]       be_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [N_REQ-1:0]                     rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic [BE_WIDTH-1:0]                  mem_be_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic                                 init_done_o
);

    typedef struct packed {
        logic                 valid;
        logic [IDX_WIDTH-1:0] idx;
        logic                 we;
    } resp_t;

    logic                  run_en;
    logic                  sweep_en;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic [IDX_WIDTH-1:0]  rr_ptr_q;
    logic                  grant_valid;
    logic [IDX_WIDTH-1:0]  winner;
    resp_t                 resp_pipe_q [MEM_LATENCY];
    resp_t                 resp_exit;

    // Index base+offset modulo N_REQ; both operands are below N_REQ, so one wrap suffices.
    function automatic logic [IDX_WIDTH-1:0] rr_index(input logic [IDX_WIDTH-1:0] base,
                                                      input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDX_WIDTH'(sum);
    endfunction

`ifdef L2_ARB_INIT_EN
    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  init_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == ADDR_WIDTH'(N_WORDS - 1)) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: state_q <= RUN;
                default: state_q <= INIT;
            endcase
        end
    end

    // The sweep is gated by rst_ni so the cut port stays quiet while reset is held.
    assign sweep_en    = rst_ni && (state_q == INIT);
    assign sweep_addr  = init_addr_q;
    assign run_en      = init_done_q;
    assign init_done_o = init_done_q;
`else
    assign sweep_en    = 1'b0;
    assign sweep_addr  = '0;
    assign run_en      = rst_ni;
    assign init_done_o = rst_ni;
`endif

    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (run_en && !grant_valid && req_i[rr_index(rr_ptr_q, k)]) begin
                grant_valid = 1'b1;
                winner      = rr_index(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (sweep_en) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = sweep_addr;
            mem_be_o   = '1;
        end else if (grant_valid) begin
            gnt_o[winner] = 1'b1;
            mem_req_o     = 1'b1;
            mem_we_o      = we_i[winner];
            mem_addr_o    = addr_i[winner];
            mem_wdata_o   = wdata_i[winner];
            mem_be_o      = be_i[winner];
        end
    end

    // NOTE: the response pipeline is reset so in-flight responses are dropped; the SRAM array itself is never reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) resp_pipe_q[s] <= '0;
        end else begin
            if (grant_valid) rr_ptr_q <= rr_index(winner, 1);
            resp_pipe_q[0] <= '{valid: grant_valid, idx: winner, we: we_i[winner]};
            for (int s = 1; s < MEM_LATENCY; s++) resp_pipe_q[s] <= resp_pipe_q[s-1];
        end
    end

    assign resp_exit = resp_pipe_q[MEM_LATENCY-1];

    // Writes are acknowledged with zero data so stale cut output never leaks to a requester.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (resp_exit.valid) begin
            rvalid_o[resp_exit.idx] = 1'b1;
            if (!resp_exit.we) rdata_o = mem_rdata_i;
        end
    end

    gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    rvalid_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Self-checking bench for l2_bank_arbiter: random requesters, behavioural SRAM cut, reference model and response scoreboard.
module tb_l2_bank_arbiter;
    localparam int N_REQ       = 4;
    localparam int DATA_WIDTH  = 64;
    localparam int N_WORDS     = 64;
    localparam int MEM_LATENCY = 2;
    localparam int ADDR_WIDTH  = $clog2(N_WORDS);
    localparam int BE_WIDTH    = DATA_WIDTH / 8;
`ifdef L2_ARB_INIT_EN
    localparam int INIT_CYCLES = N_WORDS;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic                             clk;
    logic                             rst_n;
    logic [N_REQ-1:0]                 req_i;
    logic [N_REQ-1:0]                 we_i;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [N_REQ-1:0][BE_WIDTH-1:0]   be_i;
    logic [N_REQ-1:0]                 gnt_o;
    logic [N_REQ-1:0]                 rvalid_o;
    logic [DATA_WIDTH-1:0]            rdata_o;
    logic                             mem_req_o;
    logic                             mem_we_o;
    logic [ADDR_WIDTH-1:0]            mem_addr_o;
    logic [DATA_WIDTH-1:0]            mem_wdata_o;
    logic [BE_WIDTH-1:0]              mem_be_o;
    logic [DATA_WIDTH-1:0]            mem_rdata_i;
    logic                             init_done_o;

    l2_bank_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .N_WORDS    (N_WORDS),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_rdata_i(mem_rdata_i),
        .init_done_o(init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                    idx;
        logic [DATA_WIDTH-1:0] data;
        int                    due;
    } exp_t;

    exp_t                  exp_q[$];
    logic [DATA_WIDTH-1:0] ref_mem [N_WORDS];
    logic [DATA_WIDTH-1:0] sram    [N_WORDS];
    logic [DATA_WIDTH-1:0] rd_pipe [MEM_LATENCY];
    logic [N_REQ-1:0]      granted;
    int                    rr_ptr;
    int                    cyc;
    int                    n_cmp;
    int                    n_bad;

    function automatic logic [DATA_WIDTH-1:0] be_mask(input logic [BE_WIDTH-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        for (int b = 0; b < BE_WIDTH; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fill_pattern(input int i);
        return 64'hA5A5_5A5A_0000_0000 | 64'(i);
    endfunction

    // Behavioural single-ported cut with a fixed read latency.
    assign mem_rdata_i = rd_pipe[MEM_LATENCY-1];
    always @(posedge clk) begin
        if (mem_req_o && mem_we_o)
            sram[mem_addr_o] <= (sram[mem_addr_o] & ~be_mask(mem_be_o)) | (mem_wdata_o & be_mask(mem_be_o));
        rd_pipe[0] <= (mem_req_o && !mem_we_o) ? sram[mem_addr_o] : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int s = 1; s < MEM_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Mode 0: no new requests; 1: every idle requester issues a read; 2: random mix.
    task automatic drive(input int mode);
        bit go;
        for (int j = 0; j < N_REQ; j++) begin
            if (granted[j]) req_i[j] = 1'b0;
            granted[j] = 1'b0;
            if (!req_i[j]) begin
                go = (mode == 1) || (mode == 2 && $urandom_range(0, 9) < 6);
                if (go) begin
                    req_i[j]   = 1'b1;
                    we_i[j]    = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                    addr_i[j]  = ADDR_WIDTH'($urandom_range(0, 15));
                    wdata_i[j] = {$urandom, $urandom};
                    be_i[j]    = BE_WIDTH'($urandom);
                end
            end
        end
    endtask

    // Reference model: predicts the grant and cut port for this cycle and queues the expected response.
    task automatic eval_cycle();
        bit                    ready;
        int                    win;
        int                    a;
        logic [N_REQ-1:0]      exp_gnt;
        logic [DATA_WIDTH-1:0] m;
        exp_t                  e;
        ready   = (cyc >= INIT_CYCLES);
        win     = -1;
        exp_gnt = '0;
        check("init_done", init_done_o, ready);
        if (ready) begin
            for (int k = 0; k < N_REQ; k++)
                if (win < 0 && req_i[(rr_ptr + k) % N_REQ]) win = (rr_ptr + k) % N_REQ;
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        check("gnt", gnt_o, exp_gnt);
        if (!ready) begin
            check("sweep_port", {mem_req_o, mem_we_o, mem_be_o}, {2'b11, {BE_WIDTH{1'b1}}});
            check("sweep_addr", mem_addr_o, cyc);
            check("sweep_wdata", mem_wdata_o, 0);
        end else if (win < 0) begin
            check("idle_mem_req", mem_req_o, 0);
            check("idle_payload", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
        end else begin
            a = int'(addr_i[win]);
            check("mem_req", mem_req_o, 1);
            check("mem_payload", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o},
                  {we_i[win], addr_i[win], be_i[win], wdata_i[win]});
            e.idx  = win;
            e.due  = cyc + MEM_LATENCY;
            e.data = we_i[win] ? '0 : ref_mem[a];
            exp_q.push_back(e);
            if (we_i[win]) begin
                m = be_mask(be_i[win]);
                ref_mem[a] = (ref_mem[a] & ~m) | (wdata_i[win] & m);
            end
            rr_ptr       = (win + 1) % N_REQ;
            granted[win] = 1'b1;
        end
    endtask

    // Each iteration starts 1 time unit after a rising edge.
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            drive(mode);
            #3;
            eval_cycle();
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n   = 1'b0;
        req_i   = '1;
        we_i    = '0;
        granted = '0;
        rr_ptr  = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            #3;
            check("rst_gnt", gnt_o, 0);
            check("rst_rvalid", rvalid_o, 0);
            check("rst_rdata", rdata_o, 0);
            check("rst_mem_port", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
            check("rst_init_done", init_done_o, 0);
            @(posedge clk);
            #1;
        end
        req_i = '0;
`ifdef L2_ARB_INIT_EN
        for (int i = 0; i < N_WORDS; i++) ref_mem[i] = '0;
`endif
        cyc   = 0;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a response appears, or when one is overdue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rvalid_o != '0) begin
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", rvalid_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rvalid_idx", rvalid_o, 1 << e.idx);
                        check("rdata", rdata_o, e.data);
                        check("rvalid_cycle", cyc, e.due);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    check("rvalid_missing", rvalid_o, 1 << e.idx);
                end
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        granted = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            sram[i]    = fill_pattern(i);
            ref_mem[i] = fill_pattern(i);
        end
        @(posedge clk);
        #1;
        apply_reset(3);

        // All requesters continuously requesting: strict rotation 0,1,2,3,...
        run_cycles(INIT_CYCLES + 2 * N_REQ, 1);
        run_cycles(300, 2);

        // A lone read by requester 2, then reset one cycle after its grant.
        req_i      = '0;
        granted    = '0;
        req_i[2]   = 1'b1;
        we_i[2]    = 1'b0;
        addr_i[2]  = ADDR_WIDTH'(3);
        #3;
        eval_cycle();
        check("flight_gnt", gnt_o, 4'b0100);
        @(posedge clk);
        cyc++;
        #1;
        apply_reset(MEM_LATENCY + 2);

        // Pointer must restart at 0 after reset.
        run_cycles(INIT_CYCLES + N_REQ, 1);
        run_cycles(200, 2);
        run_cycles(MEM_LATENCY + N_REQ + 4, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
